// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the CPU, burst-loader and data-RAM signals around the data-memory port arbiter.
// master: the side that drives requests and RAM read data; slave: the arbiter itself.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 5
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_stall;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              l_start;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [LEN_W-1:0]  l_len;
  logic [DATA_W-1:0] l_wdata;
  logic              l_wready;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  logic              l_busy;
  logic              l_done;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output l_start, l_we, l_addr, l_len, l_wdata,
    output m_rdata,
    input  c_gnt, c_stall, c_rvalid, c_rdata,
    input  l_wready, l_rvalid, l_rdata, l_busy, l_done,
    input  m_en, m_we, m_addr, m_wdata
  );

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  l_start, l_we, l_addr, l_len, l_wdata,
    input  m_rdata,
    output c_gnt, c_stall, c_rvalid, c_rdata,
    output l_wready, l_rvalid, l_rdata, l_busy, l_done,
    output m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-RAM port between the CPU MEM stage (priority) and a
// burst loader, with a starvation counter that forces periodic loader slots.
module dmem_port_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 5,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst_n,
  dmem_port_arbiter_if.slave bus
);
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e              state_r;
  logic                burst_we_r;
  logic [ADDR_W-1:0]   ptr_r;
  logic [LEN_W-1:0]    rem_r;
  logic [SCNT_W-1:0]   starve_r;
  logic                busy_r;
  logic                done_r;
  logic                rd_pend_r;
  logic                rd_owner_r;
  logic [DATA_W-1:0]   c_hold_r;
  logic [DATA_W-1:0]   l_hold_r;
  logic                cpu_slot_s;
  logic                ldr_slot_s;

  // Slot owner for this cycle: CPU first unless it has starved a pending burst.
  always_comb begin
    cpu_slot_s = 1'b0;
    ldr_slot_s = 1'b0;
    if (state_r == BURST) begin
      if (bus.c_req && (starve_r < STARVE_MAX)) begin
        cpu_slot_s = 1'b1;
      end else begin
        ldr_slot_s = 1'b1;
      end
    end else begin
      cpu_slot_s = bus.c_req;
    end
  end

  // Memory port and grant drive; everything is held at zero while reset is asserted.
  always_comb begin
    bus.c_gnt    = 1'b0;
    bus.l_wready = 1'b0;
    bus.m_en     = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_addr   = {ADDR_W{1'b0}};
    bus.m_wdata  = {DATA_W{1'b0}};
    if (!rst_n) begin
      bus.c_gnt = 1'b0;
    end else if (cpu_slot_s) begin
      bus.c_gnt   = 1'b1;
      bus.m_en    = 1'b1;
      bus.m_we    = bus.c_we;
      bus.m_addr  = bus.c_addr;
      bus.m_wdata = bus.c_wdata;
    end else if (ldr_slot_s) begin
      bus.l_wready = 1'b1;
      bus.m_en     = 1'b1;
      bus.m_we     = burst_we_r;
      bus.m_addr   = ptr_r;
      bus.m_wdata  = bus.l_wdata;
    end else begin
      bus.m_en = 1'b0;
    end
  end

  assign bus.c_stall = bus.c_req & ~bus.c_gnt;

  // Burst sequencer: a preempted beat leaves ptr_r/rem_r untouched so it retries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      burst_we_r <= 1'b0;
      ptr_r      <= {ADDR_W{1'b0}};
      rem_r      <= {LEN_W{1'b0}};
      starve_r   <= {SCNT_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          starve_r <= {SCNT_W{1'b0}};
          done_r   <= 1'b0;
          if (bus.l_start) begin
            burst_we_r <= bus.l_we;
            ptr_r      <= bus.l_addr;
            rem_r      <= bus.l_len;
            busy_r     <= 1'b1;
            state_r    <= BURST;
          end else begin
            busy_r <= 1'b0;
          end
        end
        BURST: begin
          if (ldr_slot_s) begin
            ptr_r    <= ptr_r + 1'b1;
            starve_r <= {SCNT_W{1'b0}};
            if (rem_r == {LEN_W{1'b0}}) begin
              state_r <= FINISH;
              done_r  <= 1'b1;
            end else begin
              rem_r <= rem_r - 1'b1;
            end
          end else begin
            starve_r <= starve_r + 1'b1;
          end
        end
        FINISH: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read-return tracking: owner tag of last cycle's read plus per-owner data hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_r  <= 1'b0;
      rd_owner_r <= 1'b0;
      c_hold_r   <= {DATA_W{1'b0}};
      l_hold_r   <= {DATA_W{1'b0}};
    end else begin
      rd_pend_r  <= (cpu_slot_s && !bus.c_we) || (ldr_slot_s && !burst_we_r);
      rd_owner_r <= ldr_slot_s;
      if (rd_pend_r) begin
        if (rd_owner_r) begin
          l_hold_r <= bus.m_rdata;
        end else begin
          c_hold_r <= bus.m_rdata;
        end
      end
    end
  end

  assign bus.c_rvalid = rd_pend_r & ~rd_owner_r;
  assign bus.l_rvalid = rd_pend_r & rd_owner_r;
  assign bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : c_hold_r;
  assign bus.l_rdata  = bus.l_rvalid ? bus.m_rdata : l_hold_r;
  assign bus.l_busy   = busy_r;
  assign bus.l_done   = done_r;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: a queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_dmem_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LW = 5;
  localparam int SLIM = 4;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) b ();

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .STARVE_LIMIT(SLIM)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous data RAM.
  logic [DW-1:0] ram [32];
  always @(posedge clk) begin
    if (b.m_en) begin
      if (b.m_we) ram[b.m_addr] <= b.m_wdata;
      else        b.m_rdata     <= ram[b.m_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [DW-1:0] ref_mem [32];
  int            q[$];
  bit            m_active, m_fin, m_bwe;
  int            starve;
  bit            pend_c, pend_l;
  logic [DW-1:0] pend_d, c_hold, l_hold;
  bit            wready_seen;

  always @(negedge clk) begin : model
    bit cpu, ldr, busy_now, fin_now;
    logic [DW-1:0] e_crd, e_lrd;
    int a;
    wready_seen = b.l_wready;
    if (!rst_n) begin
      chk("rst_c_gnt", b.c_gnt, 0);      chk("rst_c_stall", b.c_stall, b.c_req);
      chk("rst_c_rvalid", b.c_rvalid, 0); chk("rst_c_rdata", b.c_rdata, 0);
      chk("rst_l_wready", b.l_wready, 0); chk("rst_l_rvalid", b.l_rvalid, 0);
      chk("rst_l_rdata", b.l_rdata, 0);   chk("rst_l_busy", b.l_busy, 0);
      chk("rst_l_done", b.l_done, 0);     chk("rst_m_en", b.m_en, 0);
      chk("rst_m_we", b.m_we, 0);         chk("rst_m_addr", b.m_addr, 0);
      chk("rst_m_wdata", b.m_wdata, 0);
      q.delete(); m_active = 0; m_fin = 0; starve = 0;
      pend_c = 0; pend_l = 0; c_hold = '0; l_hold = '0;
    end else begin
      e_crd = pend_c ? pend_d : c_hold;
      e_lrd = pend_l ? pend_d : l_hold;
      chk("c_rvalid", b.c_rvalid, pend_c); chk("c_rdata", b.c_rdata, e_crd);
      chk("l_rvalid", b.l_rvalid, pend_l); chk("l_rdata", b.l_rdata, e_lrd);
      c_hold = e_crd; l_hold = e_lrd; pend_c = 0; pend_l = 0;
      fin_now  = m_fin;
      busy_now = m_active || fin_now;
      cpu = 0; ldr = 0;
      if (m_active) begin
        if (b.c_req && starve < SLIM) cpu = 1; else ldr = 1;
      end else begin
        cpu = b.c_req;
      end
      chk("c_gnt", b.c_gnt, cpu);
      chk("c_stall", b.c_stall, b.c_req & ~cpu);
      chk("l_wready", b.l_wready, ldr);
      chk("m_en", b.m_en, cpu | ldr);
      chk("l_busy", b.l_busy, busy_now);
      chk("l_done", b.l_done, fin_now);
      if (cpu) begin
        chk("m_we_cpu", b.m_we, b.c_we); chk("m_addr_cpu", b.m_addr, b.c_addr);
        if (b.c_we) chk("m_wdata_cpu", b.m_wdata, b.c_wdata);
      end
      if (ldr) begin
        chk("m_we_ldr", b.m_we, m_bwe); chk("m_addr_ldr", b.m_addr, q[0]);
        if (m_bwe) chk("m_wdata_ldr", b.m_wdata, b.l_wdata);
      end
      // Advance the model to the next cycle.
      m_fin = 0;
      if (cpu) begin
        if (m_active) starve = starve + 1;
        if (b.c_we) ref_mem[b.c_addr] = b.c_wdata;
        else begin pend_c = 1; pend_d = ref_mem[b.c_addr]; end
      end
      if (ldr) begin
        a = q.pop_front();
        starve = 0;
        if (m_bwe) ref_mem[a] = b.l_wdata;
        else begin pend_l = 1; pend_d = ref_mem[a]; end
        if (q.size() == 0) begin m_active = 0; m_fin = 1; end
      end
      if (!busy_now && b.l_start) begin
        for (int i = 0; i <= int'(b.l_len); i++) q.push_back((int'(b.l_addr) + i) % 32);
        m_active = 1; m_bwe = b.l_we; starve = 0;
      end
    end
  end

  int            beat;
  logic [DW-1:0] base;

  task automatic cyc();
    @(posedge clk); #1;
    if (wready_seen) begin beat = beat + 1; b.l_wdata = base + 32'(beat); end
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic start_burst(input logic we, input int addr, input int len, input logic [31:0] bs);
    b.l_start = 1'b1; b.l_we = we; b.l_addr = AW'(addr); b.l_len = LW'(len);
    beat = 0; base = bs; b.l_wdata = bs;
  endtask

  initial begin : stim
    int nw, first, last, done_at, nl, na, nr;
    bit seen;
    logic [AW-1:0] exp_a [4];
    logic [DW-1:0] exp_d [4];
    rst_n = 1'b0;
    b.c_req = 0; b.c_we = 0; b.c_addr = '0; b.c_wdata = '0;
    b.l_start = 0; b.l_we = 0; b.l_addr = '0; b.l_len = '0; b.l_wdata = '0;
    beat = 0; base = '0;
    for (int i = 0; i < 32; i++) begin ram[i] = 32'h5000_0000 + 32'(i); ref_mem[i] = 32'h5000_0000 + 32'(i); end
    ram[3] = 32'd5; ref_mem[3] = 32'd5;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // CPU read of mem[3] while idle.
    b.c_req = 1; b.c_we = 0; b.c_addr = 5'd3;
    mid(); chk("t1_gnt", b.c_gnt, 1); chk("t1_stall", b.c_stall, 0);
    cyc(); b.c_req = 0;
    mid(); chk("t1_rvalid", b.c_rvalid, 1); chk("t1_rdata", b.c_rdata, 32'd5);
    cyc();

    // Write burst 9..17 with no CPU traffic.
    start_burst(1'b1, 9, 8, 32'hA000_0000);
    cyc(); b.l_start = 0;
    nw = 0; first = -1; last = -1; done_at = -1;
    for (int k = 0; k < 30 && done_at < 0; k++) begin
      mid();
      if (b.l_wready) begin
        if (first < 0) first = k;
        last = k;
        chk("t2_addr", b.m_addr, 32'(9 + nw));
        nw++;
      end
      if (b.l_done) done_at = k;
      cyc();
    end
    chk("t2_beats", nw, 9); chk("t2_span", last - first, 8); chk("t2_done", done_at, last + 1);
    for (int i = 0; i < 9; i++) chk("t2_mem", ram[9 + i], 32'hA000_0000 + 32'(i));

    // CPU write pulse preempting the fourth loader slot.
    start_burst(1'b1, 9, 8, 32'hB000_0000);
    cyc(); b.l_start = 0;
    cyc(); cyc();
    cyc(); b.c_req = 1; b.c_we = 1; b.c_addr = 5'd25; b.c_wdata = 32'h0000_1234;
    mid(); chk("t3_gnt", b.c_gnt, 1); chk("t3_wready", b.l_wready, 0); chk("t3_caddr", b.m_addr, 25);
    cyc(); b.c_req = 0; b.c_we = 0;
    mid(); chk("t3_resume", b.l_wready, 1); chk("t3_raddr", b.m_addr, 12);
    chk("t3_rdata", b.m_wdata, 32'hB000_0003);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin mid(); if (b.l_done) seen = 1; cyc(); end
    chk("t3_done", seen, 1);

    // Read burst against a continuously requesting CPU: 4 CPU slots then 1 loader slot.
    start_burst(1'b0, 9, 8, 32'h0);
    b.c_req = 1; b.c_we = 0; b.c_addr = 5'd25;
    cyc(); b.l_start = 0;
    nl = 0; seen = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      mid();
      if (b.l_done) seen = 1;
      else begin
        chk("t4_slot", b.l_wready, (k % 5 == 0));
        if (b.l_wready) begin chk("t4_stall", b.c_stall, 1); nl++; end
      end
      cyc();
    end
    b.c_req = 0;
    chk("t4_beats", nl, 9); chk("t4_done", seen, 1);

    // Read burst wrapping 30, 31, 0, 1.
    exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0; exp_a[3] = 5'd1;
    exp_d[0] = 32'h5000_001E; exp_d[1] = 32'h5000_001F; exp_d[2] = 32'h5000_0000; exp_d[3] = 32'h5000_0001;
    start_burst(1'b0, 30, 3, 32'h0);
    cyc(); b.l_start = 0;
    na = 0; nr = 0; seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      mid();
      if (b.l_wready && na < 4) begin chk("t5_addr", b.m_addr, exp_a[na]); na++; end
      if (b.l_rvalid && nr < 4) begin
        chk("t5_rdata", b.l_rdata, exp_d[nr]); nr++;
        if (nr == 4) chk("t5_done_last", b.l_done, 1);
      end
      if (b.l_done) seen = 1;
      cyc();
    end
    chk("t5_issued", na, 4); chk("t5_returned", nr, 4);

    // Asynchronous reset in the middle of a write burst.
    start_burst(1'b1, 20, 5, 32'hC000_0000);
    cyc(); b.l_start = 0;
    cyc();
    b.c_req = 1; b.c_we = 0; b.c_addr = 5'd7;
    #2 rst_n = 1'b0;
    #1 chk("t6_m_en", b.m_en, 0); chk("t6_busy", b.l_busy, 0);
    chk("t6_wready", b.l_wready, 0); chk("t6_stall", b.c_stall, 1);
    cyc(); cyc();
    rst_n = 1'b1; b.c_req = 0;
    for (int k = 0; k < 4; k++) begin mid(); chk("t6_no_done", b.l_done, 0); chk("t6_idle", b.l_busy, 0); cyc(); end
    start_burst(1'b0, 5, 1, 32'h0);
    cyc(); b.l_start = 0;
    mid(); chk("t6_new_wready", b.l_wready, 1); chk("t6_new_addr", b.m_addr, 5);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin mid(); if (b.l_done) seen = 1; cyc(); end
    chk("t6_new_done", seen, 1);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
